// File: rtl/countdown_char_tx_if.sv
// rtl/countdown_char_tx_if.sv - start request and byte stream bundle for countdown_char_tx
interface countdown_char_tx_if;
    logic       start;
    logic [3:0] start_value;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       busy;
    logic       done;

    modport master (
        input  start,
        input  start_value,
        input  tx_ready,
        output tx_valid,
        output tx_data,
        output tx_last,
        output busy,
        output done
    );

    modport slave (
        output start,
        output start_value,
        output tx_ready,
        input  tx_valid,
        input  tx_data,
        input  tx_last,
        input  busy,
        input  done
    );
endinterface

// File: rtl/countdown_char_tx.sv
// rtl/countdown_char_tx.sv - emits an ASCII countdown N..0 with optional trailing newline
module countdown_char_tx #(
    parameter int START_MAX    = 5,
    parameter bit EMIT_NEWLINE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    countdown_char_tx_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIGIT = 2'd1,
        S_NL    = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LP_MAX = START_MAX[3:0];

    state_t     r_state;
    logic [3:0] r_count;

    state_t     w_next_state;
    logic [3:0] w_next_count;
    logic [3:0] w_start_clamped;
    logic       w_tx_valid;
    logic [7:0] w_tx_data;
    logic       w_tx_last;
    logic       w_xfer;

    // Values above START_MAX (including 10..15) collapse to START_MAX so DIGIT only ever sees 0..9.
    assign w_start_clamped = (bus.start_value > LP_MAX) ? LP_MAX : bus.start_value;
    assign w_xfer          = w_tx_valid & bus.tx_ready;

    // State and count register; async reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    // Next-state and stream outputs; outputs depend only on state so they hold while stalled.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_tx_valid   = 1'b0;
        w_tx_data    = 8'h00;
        w_tx_last    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_count = w_start_clamped;
                    w_next_state = S_DIGIT;
                end
            end
            S_DIGIT: begin
                w_tx_valid = 1'b1;
                w_tx_data  = 8'h30 + {4'd0, r_count};
                w_tx_last  = (r_count == 4'd0) && !EMIT_NEWLINE;
                if (w_xfer) begin
                    if (r_count != 4'd0) begin
                        w_next_count = r_count - 4'd1;
                    end else begin
                        w_next_state = EMIT_NEWLINE ? S_NL : S_DONE;
                    end
                end
            end
            S_NL: begin
                w_tx_valid = 1'b1;
                w_tx_data  = 8'h0A;
                w_tx_last  = 1'b1;
                if (w_xfer) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.tx_valid = w_tx_valid;
    assign bus.tx_data  = w_tx_data;
    assign bus.tx_last  = w_tx_last;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);

endmodule
